// File: rtl/spi_mem_ctrl_v2_if.sv
// Signal bundle between the CPU side, spi_mem_ctrl_v2 and the SPI SRAM pins.
// slave = controller view, master = requester/pin-side environment view.
interface spi_mem_ctrl_v2_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ready;
  logic              busy;
  logic              spi_cs_n;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, spi_miso,
    output mem_rdata, mem_ready, busy, spi_cs_n, spi_sclk, spi_mosi
  );

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, spi_miso,
    input  mem_rdata, mem_ready, busy, spi_cs_n, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/spi_mem_ctrl_v2.sv
// SPI mode-0 SRAM controller: single-byte CPU reads/writes become READ/WRITE transactions.
// Define SPI_BURST_EN to keep CS low between accesses so sequential fetches skip CMD/ADDR.
module spi_mem_ctrl_v2 #(
  parameter int ADDR_W  = 16,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_mem_ctrl_v2_if.slave bus
);

  localparam int TOT = 16 + ADDR_W;
  localparam int CW  = $clog2(TOT + 1);
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] CMD_LAST  = CW'(7);
  localparam logic [CW-1:0] ADDR_LAST = CW'(8 + ADDR_W - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(TOT - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

  if (!(ADDR_W == 8 || ADDR_W == 16 || ADDR_W == 24)) begin : g_bad_addr_w
    $error("spi_mem_ctrl_v2: ADDR_W must be 8, 16 or 24");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("spi_mem_ctrl_v2: CLK_DIV must be at least 1");
  end

`ifdef SPI_BURST_EN
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE, HOLD} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;
`endif

  state_t          state;
  state_t          state_next;
  logic [DW-1:0]   div_cnt;
  logic [CW-1:0]   bit_cnt;
  logic [TOT-2:0]  tx_sr;
  logic [7:0]      rx_sr;
  logic [7:0]      rdata_q;
  logic            sclk_q;
  logic            cs_n_q;
  logic            mosi_q;
  logic            we_q;

  logic            in_xfer;
  logic            tick;
  logic            bit_rise;
  logic            bit_fall;
  logic            last_bit;
  logic            accept_full;
  logic [TOT-1:0]  tx_load;

`ifdef SPI_BURST_EN
  localparam logic [CW-1:0] DATA_FIRST = CW'(8 + ADDR_W);

  logic [ADDR_W-1:0] last_addr;
  logic              last_we;
  logic              gap;
  logic [3:0]        hold_cnt;
  logic              burst_hit;
  logic              accept_burst;
  logic              hold_miss;
  logic              hold_timeout;
  logic [7:0]        burst_byte;
`endif

  // Bit-timing decode: SCLK toggles every CLK_DIV cycles; a fall closes one bit.
  always_comb begin
    in_xfer  = (state == CMD) || (state == ADDR) || (state == DATA);
    tick     = (div_cnt == DIV_LAST);
    bit_rise = in_xfer && tick && !sclk_q;
    bit_fall = in_xfer && tick && sclk_q;
    last_bit = (bit_cnt == BIT_LAST);
    tx_load  = {(bus.mem_we ? 8'h02 : 8'h03), bus.mem_addr,
                (bus.mem_we ? bus.mem_wdata : 8'h00)};
`ifdef SPI_BURST_EN
    burst_byte = bus.mem_we ? bus.mem_wdata : 8'h00;
    burst_hit  = (bus.mem_we == last_we) &&
                 (bus.mem_addr == ADDR_W'(last_addr + 1'b1)) &&
                 (last_addr != '1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept_full = 1'b0;
`ifdef SPI_BURST_EN
    accept_burst = 1'b0;
    hold_miss    = 1'b0;
    hold_timeout = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef SPI_BURST_EN
        if (bus.mem_req && !gap) begin
`else
        if (bus.mem_req) begin
`endif
          accept_full = 1'b1;
          state_next  = CMD;
        end
      end
      CMD:  if (bit_fall && bit_cnt == CMD_LAST)  state_next = ADDR;
      ADDR: if (bit_fall && bit_cnt == ADDR_LAST) state_next = DATA;
      DATA: if (bit_fall && last_bit)             state_next = DONE;
`ifdef SPI_BURST_EN
      DONE: state_next = HOLD;
      // A miss drops CS and lets IDLE hold it high one extra cycle via gap.
      HOLD: begin
        if (bus.mem_req) begin
          if (burst_hit) begin
            accept_burst = 1'b1;
            state_next   = DATA;
          end else begin
            hold_miss  = 1'b1;
            state_next = IDLE;
          end
        end else if (hold_cnt == 4'd15) begin
          hold_timeout = 1'b1;
          state_next   = IDLE;
        end
      end
`else
      DONE: state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Shift engine: MOSI updates with the SCLK fall, MISO is captured with the rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      if (in_xfer) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) sclk_q <= ~sclk_q;
      end
      if (bit_rise && state == DATA) rx_sr <= {rx_sr[6:0], bus.spi_miso};
      if (bit_fall) begin
        if (last_bit) begin
          mosi_q <= 1'b0;
`ifndef SPI_BURST_EN
          cs_n_q <= 1'b1;
`endif
          if (!we_q) rdata_q <= rx_sr;
        end else begin
          mosi_q  <= tx_sr[TOT-2];
          tx_sr   <= tx_sr << 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (accept_full) begin
        we_q    <= bus.mem_we;
        tx_sr   <= tx_load[TOT-2:0];
        mosi_q  <= tx_load[TOT-1];
        cs_n_q  <= 1'b0;
        sclk_q  <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= '0;
      end
`ifdef SPI_BURST_EN
      if (accept_burst) begin
        we_q    <= bus.mem_we;
        tx_sr   <= {burst_byte[6:0], {(TOT-8){1'b0}}};
        mosi_q  <= burst_byte[7];
        sclk_q  <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= DATA_FIRST;
      end
      if (hold_miss || hold_timeout) cs_n_q <= 1'b1;
`endif
    end
  end

`ifdef SPI_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr <= '0;
      last_we   <= 1'b0;
      gap       <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      if (accept_full || accept_burst) begin
        last_addr <= bus.mem_addr;
        last_we   <= bus.mem_we;
      end
      gap      <= hold_miss;
      hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : 4'd0;
    end
  end
`endif

  assign bus.spi_cs_n  = cs_n_q;
  assign bus.spi_sclk  = sclk_q;
  assign bus.spi_mosi  = mosi_q;
  assign bus.mem_rdata = rdata_q;
  assign bus.mem_ready = (state == DONE);
  assign bus.busy      = in_xfer || (state == DONE);

endmodule

// File: tb/tb_spi_mem_ctrl_v2.sv
// Bench for spi_mem_ctrl_v2: three configurations (16/2, 8/1, 24/3) share one SPI SRAM model
// and a scoreboard of expected read data; burst scenarios follow SPI_BURST_EN.
module tb_spi_mem_ctrl_v2;

`ifdef SPI_BURST_EN
  localparam int MISS_LAT = 131;
`else
  localparam int MISS_LAT = 129;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          sel = 0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [23:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        miso;

  logic        ready_v [3];
  logic        cs_v    [3];
  logic        sclk_v  [3];
  logic        mosi_v  [3];
  logic        busy_v  [3];
  logic [7:0]  rdata_v [3];

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  ref_mem [int];
  logic [7:0]  sram_mem [int];
  logic [7:0]  exp_rdata [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0]  sb [$];
  logic [7:0]  mosi_q [$];
  int          cs_rises = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int AW = (g == 0) ? 16 : (g == 1) ? 8 : 24;
    localparam int CD = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    spi_mem_ctrl_v2_if #(.ADDR_W(AW)) bus ();
    assign bus.mem_req   = req && (sel == g);
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr[AW-1:0];
    assign bus.mem_wdata = wdata;
    assign bus.spi_miso  = miso;
    assign ready_v[g] = bus.mem_ready;
    assign cs_v[g]    = bus.spi_cs_n;
    assign sclk_v[g]  = bus.spi_sclk;
    assign mosi_v[g]  = bus.spi_mosi;
    assign busy_v[g]  = bus.busy;
    assign rdata_v[g] = bus.mem_rdata;
    spi_mem_ctrl_v2 #(.ADDR_W(AW), .CLK_DIV(CD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  function automatic logic [7:0] dflt(int a);
    logic [7:0] v;
    v = a[7:0] ^ 8'h3C;
    if (a == 'h1234) v = 8'hA5;
    return v;
  endfunction

  function automatic logic [7:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [39:0] stream(int base, int n);
    logic [39:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = {s[31:0], mosi_q[base+i]};
    return s;
  endfunction

  // SPI SRAM model in sequential mode, sampling the selected DUT's pins mid-cycle.
  logic       m_cs, m_sclk, m_mosi, m_prev = 1'b0, cs_prev = 1'b1;
  logic       m_rd = 1'b0;
  logic [7:0] m_shift = '0, m_cmd = '0, m_out = '0;
  int         m_bit = 0, m_addr = 0, m_aw;

  always_comb begin
    m_cs   = cs_v[sel];
    m_sclk = sclk_v[sel];
    m_mosi = mosi_v[sel];
  end

  always @(negedge clk) begin
    m_aw = (sel == 0) ? 16 : (sel == 1) ? 8 : 24;
    if (m_cs && !cs_prev) cs_rises++;
    cs_prev = m_cs;
    if (m_cs) begin
      m_bit = 0;
      m_rd  = 1'b0;
      miso  = 1'b0;
    end else begin
      if (m_sclk && !m_prev) begin
        m_shift = {m_shift[6:0], m_mosi};
        m_bit++;
        if (m_bit % 8 == 0) begin
          mosi_q.push_back(m_shift);
          if (m_bit == 8) begin
            m_cmd  = m_shift;
            m_addr = 0;
          end else if (m_bit <= 8 + m_aw) begin
            m_addr = (m_addr << 8) | int'(m_shift);
            if (m_bit == 8 + m_aw && m_cmd == 8'h03) begin
              m_rd  = 1'b1;
              m_out = sram_mem.exists(m_addr) ? sram_mem[m_addr] : dflt(m_addr);
            end
          end else begin
            if (m_cmd == 8'h02) sram_mem[m_addr] = m_shift;
            m_addr = (m_addr + 1) & ((1 << m_aw) - 1);
            if (m_rd) m_out = sram_mem.exists(m_addr) ? sram_mem[m_addr] : dflt(m_addr);
          end
        end
      end else if (!m_sclk && m_prev && m_rd) begin
        miso  = m_out[7];
        m_out = {m_out[6:0], 1'b0};
      end
    end
    m_prev = m_sclk;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one request from cycle 0, waits for mem_ready and pops the scoreboard.
  task automatic run_access(input int s, input logic w, input int a, input logic [7:0] d,
                            output int lat, output logic [7:0] got, output logic [7:0] expv,
                            output logic cs_done);
    logic [7:0] e;
    if (w) begin
      ref_mem[a] = d;
      e = exp_rdata[s];
    end else begin
      e = ref_rd(a);
    end
    exp_rdata[s] = e;
    sb.push_back(e);
    sel = s; we = w; addr = a[23:0]; wdata = d; req = 1'b1;
    lat = -1;
    cs_done = 1'b0;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge clk); #1;
      if (ready_v[s]) begin
        lat = n;
        cs_done = cs_v[s];
        break;
      end
    end
    req = 1'b0;
    got = rdata_v[s];
    expv = sb.pop_front();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cs_v[0] !== 1'b1) begin failures++; $display("[TB] FAIL rst_cs got=%b exp=1", cs_v[0]); end
    checks++; if (sclk_v[0] !== 1'b0) begin failures++; $display("[TB] FAIL rst_sclk got=%b exp=0", sclk_v[0]); end
    checks++; if (mosi_v[0] !== 1'b0) begin failures++; $display("[TB] FAIL rst_mosi got=%b exp=0", mosi_v[0]); end
    checks++; if (ready_v[0] !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready got=%b exp=0", ready_v[0]); end
    checks++; if (busy_v[0] !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%b exp=0", busy_v[0]); end
    checks++; if (rdata_v[0] !== 8'h00) begin failures++; $display("[TB] FAIL rst_rdata got=%h exp=00", rdata_v[0]); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_read();
    int lat, base; logic [7:0] got, e; logic csd;
    base = mosi_q.size();
    run_access(0, 1'b0, 'h1234, 8'h00, lat, got, e, csd);
    checks++; if (lat !== 129) begin failures++; $display("[TB] FAIL read_lat got=%0d exp=129", lat); end
    checks++; if (got !== e) begin failures++; $display("[TB] FAIL read_data got=%h exp=%h", got, e); end
    checks++; if (stream(base, 4) !== 40'h0003123400) begin failures++; $display("[TB] FAIL read_mosi got=%h exp=03123400", stream(base, 4)); end
`ifdef SPI_BURST_EN
    checks++; if (csd !== 1'b0) begin failures++; $display("[TB] FAIL read_cs_done got=%b exp=0", csd); end
`else
    checks++; if (csd !== 1'b1 || cs_v[0] !== 1'b1) begin failures++; $display("[TB] FAIL read_cs_gap got=%b%b exp=11", csd, cs_v[0]); end
`endif
    idle(20);
  endtask

  task automatic test_write();
    int lat, base; logic [7:0] got, e; logic csd;
    run_access(1, 1'b0, 'h80, 8'h00, lat, got, e, csd);
    checks++; if (got !== e) begin failures++; $display("[TB] FAIL w8_preread got=%h exp=%h", got, e); end
    idle(20);
    base = mosi_q.size();
    run_access(1, 1'b1, 'h80, 8'h5A, lat, got, e, csd);
    checks++; if (lat !== 49) begin failures++; $display("[TB] FAIL w8_lat got=%0d exp=49", lat); end
    checks++; if (got !== e) begin failures++; $display("[TB] FAIL w8_rdata_kept got=%h exp=%h", got, e); end
    checks++; if (stream(base, 3) !== 40'h000002805A) begin failures++; $display("[TB] FAIL w8_mosi got=%h exp=02805a", stream(base, 3)); end
    idle(20);
    run_access(1, 1'b0, 'h80, 8'h00, lat, got, e, csd);
    checks++; if (got !== e) begin failures++; $display("[TB] FAIL w8_readback got=%h exp=%h", got, e); end
    idle(20);
  endtask

  task automatic test_burst();
    int lat, base, r; logic [7:0] got, e; logic csd;
    base = mosi_q.size();
    run_access(0, 1'b0, 'h10, 8'h00, lat, got, e, csd);
    checks++; if (lat !== 129) begin failures++; $display("[TB] FAIL burst_first_lat got=%0d exp=129", lat); end
    r = cs_rises;
    run_access(0, 1'b0, 'h11, 8'h00, lat, got, e, csd);
    checks++; if (got !== e) begin failures++; $display("[TB] FAIL burst_next_data got=%h exp=%h", got, e); end
`ifdef SPI_BURST_EN
    checks++; if (lat !== 33) begin failures++; $display("[TB] FAIL burst_hit_lat got=%0d exp=33", lat); end
    checks++; if (cs_rises !== r) begin failures++; $display("[TB] FAIL burst_cs_rises got=%0d exp=%0d", cs_rises, r); end
    checks++; if (stream(base, 5) !== 40'h0300100000) begin failures++; $display("[TB] FAIL burst_mosi got=%h exp=0300100000", stream(base, 5)); end
    r = cs_rises;
    base = mosi_q.size();
    run_access(0, 1'b0, 'h40, 8'h00, lat, got, e, csd);
    checks++; if (lat !== 131) begin failures++; $display("[TB] FAIL burst_miss_lat got=%0d exp=131", lat); end
    checks++; if (got !== e) begin failures++; $display("[TB] FAIL burst_miss_data got=%h exp=%h", got, e); end
    checks++; if (cs_rises !== r + 1) begin failures++; $display("[TB] FAIL burst_miss_cs got=%0d exp=%0d", cs_rises, r + 1); end
    checks++; if (stream(base, 4) !== 40'h0003004000) begin failures++; $display("[TB] FAIL burst_miss_mosi got=%h exp=03004000", stream(base, 4)); end
`else
    checks++; if (lat !== 129) begin failures++; $display("[TB] FAIL seq_lat got=%0d exp=129", lat); end
    checks++; if (cs_rises !== r + 1) begin failures++; $display("[TB] FAIL seq_cs_rises got=%0d exp=%0d", cs_rises, r + 1); end
`endif
    idle(20);
  endtask

  task automatic test_boundaries();
    int lat; logic [7:0] got, e; logic csd;
    run_access(0, 1'b0, 'hFFFF, 8'h00, lat, got, e, csd);
    checks++; if (got !== e) begin failures++; $display("[TB] FAIL top_addr_data got=%h exp=%h", got, e); end
    run_access(0, 1'b0, 'h0000, 8'h00, lat, got, e, csd);
    checks++; if (lat !== MISS_LAT) begin failures++; $display("[TB] FAIL wrap_lat got=%0d exp=%0d", lat, MISS_LAT); end
    checks++; if (got !== e) begin failures++; $display("[TB] FAIL wrap_data got=%h exp=%h", got, e); end
    run_access(0, 1'b1, 'h0001, 8'h77, lat, got, e, csd);
    checks++; if (lat !== MISS_LAT) begin failures++; $display("[TB] FAIL we_change_lat got=%0d exp=%0d", lat, MISS_LAT); end
    run_access(0, 1'b0, 'h0002, 8'h00, lat, got, e, csd);
    checks++; if (lat !== MISS_LAT) begin failures++; $display("[TB] FAIL rd_after_wr_lat got=%0d exp=%0d", lat, MISS_LAT); end
    checks++; if (got !== e) begin failures++; $display("[TB] FAIL rd_after_wr_data got=%h exp=%h", got, e); end
`ifdef SPI_BURST_EN
    idle(15);
    checks++; if (cs_v[0] !== 1'b0) begin failures++; $display("[TB] FAIL hold_cs_16th got=%b exp=0", cs_v[0]); end
    idle(1);
    checks++; if (cs_v[0] !== 1'b1) begin failures++; $display("[TB] FAIL hold_timeout_cs got=%b exp=1", cs_v[0]); end
`else
    checks++; if (cs_v[0] !== 1'b1) begin failures++; $display("[TB] FAIL idle_cs got=%b exp=1", cs_v[0]); end
`endif
    idle(20);
  endtask

  task automatic test_async_reset();
    int lat; logic [7:0] got, e; logic csd;
    run_access(0, 1'b0, 'h1234, 8'h00, lat, got, e, csd);
    idle(20);
    sel = 0; we = 1'b0; addr = 24'h001234; req = 1'b1;
    idle(47);
    checks++; if ({busy_v[0], sclk_v[0], mosi_v[0]} !== 3'b111) begin failures++; $display("[TB] FAIL pre_abort got=%b exp=111", {busy_v[0], sclk_v[0], mosi_v[0]}); end
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    checks++; if ({cs_v[0], sclk_v[0], mosi_v[0], ready_v[0], busy_v[0]} !== 5'b10000) begin
      failures++; $display("[TB] FAIL abort_pins got=%b exp=10000", {cs_v[0], sclk_v[0], mosi_v[0], ready_v[0], busy_v[0]});
    end
    checks++; if (rdata_v[0] !== 8'h00) begin failures++; $display("[TB] FAIL abort_rdata got=%h exp=00", rdata_v[0]); end
    for (int i = 0; i < 3; i++) exp_rdata[i] = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    run_access(0, 1'b0, 'h1234, 8'h00, lat, got, e, csd);
    checks++; if (lat !== 129) begin failures++; $display("[TB] FAIL post_reset_lat got=%0d exp=129", lat); end
    checks++; if (got !== e) begin failures++; $display("[TB] FAIL post_reset_data got=%h exp=%h", got, e); end
    idle(20);
  endtask

  task automatic test_addr24();
    int lat, base; logic [7:0] got, e; logic csd;
    base = mosi_q.size();
    run_access(2, 1'b0, 'h012345, 8'h00, lat, got, e, csd);
    checks++; if (lat !== 241) begin failures++; $display("[TB] FAIL a24_lat got=%0d exp=241", lat); end
    checks++; if (got !== e) begin failures++; $display("[TB] FAIL a24_data got=%h exp=%h", got, e); end
    checks++; if (stream(base, 5) !== 40'h0301234500) begin failures++; $display("[TB] FAIL a24_mosi got=%h exp=0301234500", stream(base, 5)); end
    idle(20);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_burst();
    test_boundaries();
    test_async_reset();
    test_addr24();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

endmodule
